// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential shift-add multiplier, unsigned or two's complement
//
// Purpose: multiplies two WIDTH-bit operands in WIDTH shift-add steps plus one
// sign-fix cycle. Signed operands are reduced to magnitudes at start, and the
// product is negated in the FIX cycle when the operand signs differ.
//
// Ports:
//   clk    in   1         rising-edge clock
//   clr_n  in   1         asynchronous active-low reset
//   start  in   1         request a multiply (accepted only in IDLE)
//   sgn    in   1         0 = unsigned, 1 = two's complement (sampled with start)
//   da     in   WIDTH     multiplicand (sampled with start)
//   db     in   WIDTH     multiplier   (sampled with start)
//   busy   out  1         high while a multiply is in progress
//   done   out  1         one-cycle pulse when p takes a new result
//   p      out  2*WIDTH   product, held until the next result

module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   da,
  input  logic [WIDTH-1:0]   db,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic               r_done;
  logic [2*WIDTH-1:0] r_p;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic               w_last;

  // Magnitudes fit in WIDTH unsigned bits: -2^(WIDTH-1) negates to the
  // bit pattern 2^(WIDTH-1), which is exactly its magnitude read unsigned.
  assign w_mag_a = (sgn && da[WIDTH-1]) ? ((~da) + WIDTH'(1)) : da;
  assign w_mag_b = (sgn && db[WIDTH-1]) ? ((~db) + WIDTH'(1)) : db;

  // Upper half of r_acc is the partial product, lower half starts as the
  // multiplier and is consumed LSB-first as the accumulator shifts right.
  assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next = ST_CALC;
      ST_CALC: if (w_last) w_next = ST_FIX;
      ST_FIX:              w_next = ST_IDLE;
      default:             w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_done  <= 1'b0;
      r_p     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand <= w_mag_a;
            r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
            r_cnt   <= '0;
            r_neg   <= sgn & (da[WIDTH-1] ^ db[WIDTH-1]);
          end
        end
        ST_CALC: begin
          // Carry out of the add lands in the MSB after the shift.
          r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
        end
        ST_FIX: begin
          // Negating a zero magnitude yields zero, so no special case needed.
          r_p    <= r_neg ? ((~r_acc) + (2*WIDTH)'(1)) : r_acc;
          r_done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign p    = r_p;

endmodule
